// File: rtl/la_dmuxi4_pkg.sv
// Shared constants for the la_dmuxi4 receive-side deserializer:
// FSM state encoding and the number of lanes per frame.
package la_dmuxi4_pkg;

   typedef enum logic {
      SYNC    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   localparam int LANES = 4;

endpackage

// File: rtl/la_dmux_lane.sv
// One shadow-register bit: captures d on a rising clock edge when en is high.
module la_dmux_lane (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= 1'b0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/la_dmuxi4.sv
// 1-to-4 inverting demultiplexer/deserializer: gathers four lane bits in
// order and presents them as one registered frame behind a valid/ready handshake.
module la_dmuxi4
   import la_dmuxi4_pkg::*;
#(
   parameter     PROP   = "DEFAULT",
   parameter int INVERT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic zn,
   input  logic s0,
   input  logic s1,
   input  logic in_valid,
   output logic q0,
   output logic q1,
   output logic q2,
   output logic q3,
   output logic out_valid,
   input  logic out_ready,
   output logic err,
   output logic overflow
);

   state_t             state;
   state_t             state_next;
   logic [1:0]         exp;
   logic [1:0]         exp_next;
   logic [1:0]         sel;
   logic               bit_in;
   logic               complete;
   logic               err_next;
   logic [LANES-1:0]   cap_en;
   logic [LANES-1:0]   shadow;
   logic [LANES-1:0]   frame_next;
   logic [LANES-1:0]   q_reg;

   // PROP only steers technology mapping; the behaviour is identical for every value.
   if (PROP != "DEFAULT") begin : g_prop_mapped
   end

   assign sel    = {s1, s0};
   assign bit_in = (INVERT != 0) ? ~zn : zn;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      la_dmux_lane u_lane (
         .clk   (clk),
         .reset (reset),
         .en    (cap_en[i]),
         .d     (bit_in),
         .q     (shadow[i])
      );
   end

   // The frame as it will sit in the shadow register once this edge's capture lands.
   assign frame_next = (shadow & ~cap_en) | (cap_en & {LANES{bit_in}});

   always_comb begin
      state_next = state;
      exp_next   = exp;
      cap_en     = '0;
      complete   = 1'b0;
      err_next   = 1'b0;
      if (in_valid) begin
         unique case (state)
            SYNC: begin
               if (sel == 2'd0) begin
                  cap_en[0]  = 1'b1;
                  exp_next   = 2'd1;
                  state_next = COLLECT;
               end
            end
            COLLECT: begin
               if (sel == exp) begin
                  cap_en[sel] = 1'b1;
                  if (exp == 2'd3) begin
                     complete   = 1'b1;
                     exp_next   = 2'd0;
                     state_next = SYNC;
                  end else begin
                     exp_next = exp + 2'd1;
                  end
               end else begin
                  err_next = 1'b1;
                  if (sel == 2'd0) begin
                     cap_en[0] = 1'b1;
                     exp_next  = 2'd1;
                  end else begin
                     exp_next   = 2'd0;
                     state_next = SYNC;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SYNC;
         exp   <= 2'd0;
      end else begin
         state <= state_next;
         exp   <= exp_next;
      end
   end

   // A completing frame wins over a plain handshake, so out_valid never dips.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_reg     <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         err      <= err_next;
         overflow <= 1'b0;
         if (complete) begin
            if (!out_valid || out_ready) begin
               q_reg     <= frame_next;
               out_valid <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign q0 = q_reg[0];
   assign q1 = q_reg[1];
   assign q2 = q_reg[2];
   assign q3 = q_reg[3];

endmodule

// File: tb/tb_la_dmuxi4.sv
// Scoreboard bench for la_dmuxi4 (INVERT=1): directed lane sequences push
// expected frames and per-cycle err/overflow values; a monitor pops and compares.
module tb_la_dmuxi4;

   logic clk = 1'b0;
   logic reset;
   logic zn;
   logic s0;
   logic s1;
   logic in_valid;
   logic out_ready;
   logic q0;
   logic q1;
   logic q2;
   logic q3;
   logic out_valid;
   logic err;
   logic overflow;
   logic [3:0] q_bus;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      longint due;
      logic   e_err;
      logic   e_ovf;
   } flag_t;

   flag_t      flag_q[$];
   logic [3:0] frame_q[$];

   la_dmuxi4 #(
      .PROP   ("DEFAULT"),
      .INVERT (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .zn        (zn),
      .s0        (s0),
      .s1        (s1),
      .in_valid  (in_valid),
      .q0        (q0),
      .q1        (q1),
      .q2        (q2),
      .q3        (q3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err),
      .overflow  (overflow)
   );

   assign q_bus = {q3, q2, q1, q0};

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] req);
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   // Inputs change 1 unit after a rising edge; the flag expectation is due at
   // the falling edge that follows the edge sampling these inputs.
   task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic z,
                                input logic rdy, input logic e_err, input logic e_ovf);
      flag_t fe;
      @(posedge clk);
      #1;
      in_valid  = v;
      {s1, s0}  = sel;
      zn        = z;
      out_ready = rdy;
      fe.due    = longint'($time) + 14;
      fe.e_err  = e_err;
      fe.e_ovf  = e_ovf;
      flag_q.push_back(fe);
   endtask

   task automatic sendFrame(input logic [3:0] zn_bits, input logic rdy_last, input logic ovf_last);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 2'(i), zn_bits[i], (i == 3) ? rdy_last : 1'b0,
                       1'b0, (i == 3) ? ovf_last : 1'b0);
      end
   endtask

   // Monitor: falling edge sees post-edge outputs and the ready the next edge will sample.
   initial begin
      flag_t fe;
      logic [3:0] want;
      forever begin
         @(negedge clk);
         while (flag_q.size() > 0 && flag_q[0].due <= longint'($time)) begin
            fe = flag_q.pop_front();
            checkOutput("err", {3'b000, err}, {3'b000, fe.e_err});
            checkOutput("overflow", {3'b000, overflow}, {3'b000, fe.e_ovf});
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (frame_q.size() == 0) begin
               n_checks++;
               $display("[TB] FAIL unexpected_frame: got %b, expected no frame", q_bus);
            end else begin
               want = frame_q.pop_front();
               checkOutput("frame", q_bus, want);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      zn        = 1'b0;
      s0        = 1'b0;
      s1        = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_q", q_bus, 4'b0000);
      checkOutput("reset_out_valid", {3'b000, out_valid}, 4'b0000);
      checkOutput("reset_err", {3'b000, err}, 4'b0000);
      checkOutput("reset_overflow", {3'b000, overflow}, 4'b0000);
      reset = 1'b0;

      $display("[TB] basic frame zn=0,1,1,0");
      sendFrame(4'b0110, 1'b0, 1'b0);
      frame_q.push_back(4'b1001);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_out_valid", {3'b000, out_valid}, 4'b0001);
      checkOutput("t1_q", q_bus, 4'b1001);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("[TB] out-of-order 0,1,3 then clean frame");
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      sendFrame(4'b1101, 1'b0, 1'b0);
      frame_q.push_back(4'b0010);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("[TB] restart on lane 0 mid-frame");
      applyStimulus(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      frame_q.push_back(4'b0011);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("[TB] back-to-back frames with consumer stalled");
      sendFrame(4'b1010, 1'b0, 1'b0);
      frame_q.push_back(4'b0101);
      sendFrame(4'b0101, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t4_q_held", q_bus, 4'b0101);
      checkOutput("t4_out_valid", {3'b000, out_valid}, 4'b0001);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("[TB] frame completes during handshake");
      sendFrame(4'b0000, 1'b0, 1'b0);
      frame_q.push_back(4'b1111);
      sendFrame(4'b1001, 1'b1, 1'b0);
      frame_q.push_back(4'b0110);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t5_out_valid", {3'b000, out_valid}, 4'b0001);
      checkOutput("t5_q", q_bus, 4'b0110);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("[TB] async reset mid-frame");
      sendFrame(4'b1110, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t6_q_pending", q_bus, 4'b0001);
      applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      checkOutput("t6_reset_q", q_bus, 4'b0000);
      checkOutput("t6_reset_out_valid", {3'b000, out_valid}, 4'b0000);
      checkOutput("t6_reset_err", {3'b000, err}, 4'b0000);
      checkOutput("t6_reset_overflow", {3'b000, overflow}, 4'b0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t6_no_frame", {3'b000, out_valid}, 4'b0000);
      sendFrame(4'b1011, 1'b0, 1'b0);
      frame_q.push_back(4'b0100);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 20 && (flag_q.size() > 0 || frame_q.size() > 0); i++) begin
         @(negedge clk);
      end
      n_checks++;
      if (flag_q.size() == 0 && frame_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL drain: got %0d frames and %0d flag slots left, expected 0 and 0",
                  frame_q.size(), flag_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
